bcd_seg_mux: RTL and testbench

Downstream consumer of the two-digit BCD counter (bcd_lsb, bcd_msb). It snapshots the digit pair on a load strobe and drives one time-multiplexed, two-digit 7-segment display. The display has shared segment lines and one enable per digit. A dead-time gap between digits prevents ghosting; optional leading-zero blanking and a sticky invalid-digit flag are provided.

---
 rtl/bcd_disp_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_seg_mux.sv | 150 +++++++++++++++
 tb/tb_bcd_seg_mux.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the multiplexed two-digit BCD display.
package bcd_disp_pkg;

    // Refresh slot sequence; each slot owns the shared segment lines for a while.
    typedef enum logic [1:0] {
        ShowLsb  = 2'd0,
        GapToMsb = 2'd1,
        ShowMsb  = 2'd2,
        GapToLsb = 2'd3
    } disp_state_e;

    // Logical (active-high) segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to logical 7-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Table lookup; 10..15 fall through to the dash.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_mux.sv
// Snapshots a two-digit BCD value and drives a time-multiplexed 7-segment display
// with dead-time gaps, optional leading-zero blanking and a sticky invalid-digit flag.
module bcd_seg_mux
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GAP_CYCLES   = 8,
    parameter int unsigned COMMON_ANODE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd_lsb,
    input  logic [3:0] bcd_msb,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick,
    output logic       err
);

    localparam int unsigned CntMax = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] ShowLast = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    // Physical polarity masks: common anode pins are active-low.
    localparam logic [6:0] SegInv = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AnInv  = (COMMON_ANODE != 0) ? 2'b11 : 2'b00;

    disp_state_e     r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [3:0]      r_snap_lsb, r_snap_msb;
    logic            r_err;
    logic [6:0]      r_seg;
    logic [1:0]      r_an;
    logic            r_frame_tick;

    logic [3:0]      w_digit;
    logic [6:0]      w_seg7;
    logic [6:0]      w_seg_log;
    logic [1:0]      w_an_log;
    logic            w_tick;

    // Snapshot registers and the sticky invalid-digit flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_lsb <= 4'd0;
            r_snap_msb <= 4'd0;
            r_err      <= 1'b0;
        end else if (load) begin
            r_snap_lsb <= bcd_lsb;
            r_snap_msb <= bcd_msb;
            r_err      <= r_err | (bcd_lsb > 4'd9) | (bcd_msb > 4'd9);
        end
    end

    // Slot state and slot counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ShowLsb;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Next slot: advance when the counter reaches the slot length, restarting the count.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        unique case (r_state)
            ShowLsb: begin
                if (r_cnt == ShowLast) begin
                    w_state_d = GapToMsb;
                    w_cnt_d   = '0;
                end
            end
            GapToMsb: begin
                if (r_cnt == GapLast) begin
                    w_state_d = ShowMsb;
                    w_cnt_d   = '0;
                end
            end
            ShowMsb: begin
                if (r_cnt == ShowLast) begin
                    w_state_d = GapToLsb;
                    w_cnt_d   = '0;
                end
            end
            GapToLsb: begin
                if (r_cnt == GapLast) begin
                    w_state_d = ShowLsb;
                    w_cnt_d   = '0;
                end
            end
        endcase
    end

    assign w_digit = (r_state == ShowMsb) ? r_snap_msb : r_snap_lsb;

    bcd_to_seg7 u_dec (
        .i_digit (w_digit),
        .o_seg   (w_seg7)
    );

    // Logical pin values for the current slot; gaps and a blanked tens digit are dark.
    always_comb begin
        w_seg_log = SEG_OFF;
        w_an_log  = 2'b00;
        w_tick    = (r_state == ShowLsb) && (r_cnt == '0);
        unique case (r_state)
            ShowLsb: begin
                w_seg_log = w_seg7;
                w_an_log  = 2'b01;
            end
            ShowMsb: begin
                if (!(blank_lz && (r_snap_msb == 4'd0))) begin
                    w_seg_log = w_seg7;
                    w_an_log  = 2'b10;
                end
            end
            default: begin
                w_seg_log = SEG_OFF;
                w_an_log  = 2'b00;
            end
        endcase
    end

    // Output registers at physical polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg        <= SEG_OFF ^ SegInv;
            r_an         <= 2'b00 ^ AnInv;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_log ^ SegInv;
            r_an         <= w_an_log ^ AnInv;
            r_frame_tick <= w_tick;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;
    assign err        = r_err;

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Self-checking bench: directed scenarios plus random traffic against a frame-position model.
module tb_bcd_seg_mux;

    localparam int unsigned R  = 4;
    localparam int unsigned G  = 1;
    localparam int unsigned CA = 1;
    localparam int unsigned F  = 2 * (R + G);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] bcd_lsb = 4'd0;
    logic [3:0] bcd_msb = 4'd0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    bcd_seg_mux #(
        .REFRESH_DIV  (R),
        .GAP_CYCLES   (G),
        .COMMON_ANODE (CA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_lsb    (bcd_lsb),
        .bcd_msb    (bcd_msb),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Position p within the frame: [0,R) units, [R,R+G) gap, [R+G,2R+G) tens, rest gap.
    function automatic logic [6:0] model_seg(input int p, input logic [3:0] l,
                                             input logic [3:0] m, input logic blz);
        logic [6:0] s;
        s = 7'h00;
        if (p < R) s = dec(l);
        else if (p >= R + G && p < 2 * R + G && !(blz && m == 4'd0)) s = dec(m);
        return (CA != 0) ? ~s : s;
    endfunction

    function automatic logic [1:0] model_an(input int p, input logic [3:0] m, input logic blz);
        logic [1:0] a;
        a = 2'b00;
        if (p < R) a = 2'b01;
        else if (p >= R + G && p < 2 * R + G && !(blz && m == 4'd0)) a = 2'b10;
        return (CA != 0) ? ~a : a;
    endfunction

    int         m_k = 0;
    logic [3:0] m_lsb = 4'd0;
    logic [3:0] m_msb = 4'd0;
    logic       m_err = 1'b0;
    logic       m_valid = 1'b0;
    logic [6:0] exp_seg = 7'h00;
    logic [1:0] exp_an = 2'b00;
    logic       exp_ft = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_k     <= 0;
            m_lsb   <= 4'd0;
            m_msb   <= 4'd0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
            exp_seg <= (CA != 0) ? 7'h7F : 7'h00;
            exp_an  <= (CA != 0) ? 2'b11 : 2'b00;
            exp_ft  <= 1'b0;
        end else begin
            exp_seg <= model_seg(m_k, m_lsb, m_msb, blank_lz);
            exp_an  <= model_an(m_k, m_msb, blank_lz);
            exp_ft  <= (m_k == 0);
            m_k     <= (m_k + 1) % F;
            if (load) begin
                m_lsb <= bcd_lsb;
                m_msb <= bcd_msb;
                m_err <= m_err | (bcd_lsb > 4'd9) | (bcd_msb > 4'd9);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_seg", 32'(seg), 32'(exp_seg));
            chk("model_an", 32'(an), 32'(exp_an));
            chk("model_frame_tick", 32'(frame_tick), 32'(exp_ft));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        tick();
        tick();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'h3);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_ft", 32'(frame_tick), 32'h0);
    endtask

    // Release reset with a load on the first free-running edge (E0).
    task automatic release_with_load(input logic [3:0] l, input logic [3:0] m);
        reset   = 1'b0;
        load    = 1'b1;
        bcd_lsb = l;
        bcd_msb = m;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // 1/2: reset, then load 7/3 and watch one whole frame.
        do_reset();
        release_with_load(4'd7, 4'd3);
        chk("t1_an", 32'(an), 32'h2);
        chk("t1_seg", 32'(seg), 32'h40);
        chk("t1_ft", 32'(frame_tick), 32'h1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= 3 || k == 10) begin
                chk("t2_units_seg", 32'(seg), 32'h78);
                chk("t2_units_an", 32'(an), 32'h2);
            end else if (k == 4 || k == 9) begin
                chk("t2_gap_seg", 32'(seg), 32'h7F);
                chk("t2_gap_an", 32'(an), 32'h3);
            end else begin
                chk("t2_tens_seg", 32'(seg), 32'h30);
                chk("t2_tens_an", 32'(an), 32'h1);
            end
            chk("t2_ft", 32'(frame_tick), (k == 10) ? 32'h1 : 32'h0);
        end

        // 3: leading-zero blanking on tens = 0.
        do_reset();
        blank_lz = 1'b1;
        release_with_load(4'd5, 4'd0);
        for (int k = 1; k <= 5; k++) tick();
        chk("t3_blank_an", 32'(an), 32'h3);
        chk("t3_blank_seg", 32'(seg), 32'h7F);
        blank_lz = 1'b0;
        tick();
        chk("t3_zero_an", 32'(an), 32'h1);
        chk("t3_zero_seg", 32'(seg), 32'h40);

        // 4: invalid digit sets sticky err; dash shown; reset clears.
        do_reset();
        release_with_load(4'd12, 4'd1);
        chk("t4_err_set", 32'(err), 32'h1);
        load    = 1'b1;
        bcd_lsb = 4'd2;
        bcd_msb = 4'd3;
        tick();
        load = 1'b0;
        chk("t4_dash", 32'(seg), 32'h3F);
        chk("t4_err_hold", 32'(err), 32'h1);
        tick();
        chk("t4_seg_2", 32'(seg), 32'h24);
        chk("t4_err_hold2", 32'(err), 32'h1);
        do_reset();
        chk("t4_err_clr", 32'(err), 32'h0);

        // 5: load mid-slot; pins change one edge after the capture edge, timing unchanged.
        release_with_load(4'd1, 4'd2);
        tick();
        load    = 1'b1;
        bcd_lsb = 4'd8;
        tick();
        load = 1'b0;
        chk("t5_old_digit", 32'(seg), 32'h79);
        tick();
        chk("t5_new_digit", 32'(seg), 32'h00);
        for (int k = 4; k <= 10; k++) tick();
        chk("t5_ft_period", 32'(frame_tick), 32'h1);

        // 6: reset in the tens slot with load on the same edge.
        do_reset();
        release_with_load(4'd4, 4'd6);
        for (int k = 1; k <= 6; k++) tick();
        chk("t6_in_tens", 32'(an), 32'h1);
        reset   = 1'b1;
        load    = 1'b1;
        bcd_lsb = 4'd9;
        bcd_msb = 4'd9;
        tick();
        chk("t6_rst_an", 32'(an), 32'h3);
        reset = 1'b0;
        load  = 1'b0;
        tick();
        chk("t6_restart_an", 32'(an), 32'h2);
        chk("t6_restart_seg", 32'(seg), 32'h40);
        chk("t6_restart_ft", 32'(frame_tick), 32'h1);

        // Random traffic; the model compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(99) == 0);
            load     = ($urandom_range(3) == 0);
            bcd_lsb  = 4'($urandom_range(15));
            bcd_msb  = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
            blank_lz = ($urandom_range(1) == 1);
            tick();
        end

        reset = 1'b0;
        load  = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
